dht11_read_sequencer: RTL
=========================

// Module: dht11_read_sequencer
// PURPOSE
//  Sequences one DHT11 read transaction around the 40-bit bit-level data receiver:
//  - drives the host start pulse and qualifies the sensor's 80us/80us response;
//  - arms the receiver, waits for its frame, and validates the checksum;
//  - enforces the sensor's minimum re-read interval.
//  Sits between the top-level request/display logic and the receiver. It owns the
//  open-drain control of the single-wire bus outside the data phase.
// PARAMETERS
//  TICKS_PER_US     50        clk cycles per microsecond (50 MHz clock)
//  START_LOW_US     18000     host start-pulse low time
//  RESP_TIMEOUT_US  100       max wait for sensor to pull low after release
//  RESP_MIN_US      40        min legal duration of each response phase (low, high)
//  RESP_MAX_US      120       max legal duration of each response phase
//  FRAME_TIMEOUT_US 6000      max time from rx_start to rx_done
//  HOLDOFF_US       1000000   min interval from transaction end to next start
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-low
//  start_req   in   1   one-cycle request for a new reading
//  dht_in      in   1   raw bus level (asynchronous; synchronized inside)
//  dht_oe      out  1   1 = drive bus low; 0 = release (tri-state at top level)
//  rx_start    out  1   one-cycle pulse that arms the bit receiver
//  rx_done     in   1   one-cycle pulse from receiver: frame complete
//  rx_data     in   40  receiver frame {hum_int,hum_dec,tmp_int,tmp_dec,chk}; valid with rx_done
//  busy        out  1   high from accepted start_req until HOLDOFF ends
//  hum         out  16  humidity {int,dec}; updates only on a good frame
//  temp        out  16  temperature {int,dec}; updates only on a good frame
//  valid       out  1   one-cycle pulse: hum/temp just updated
//  err         out  1   one-cycle pulse: transaction failed
//  err_code    out  2   01 no/bad response, 10 frame timeout, 11 checksum; held until next err
// BEHAVIOUR
//  Reset (rst==0 at posedge clk):
//  - outputs: dht_oe=0, rx_start=0, busy=0, hum=0, temp=0, valid=0, err=0, err_code=00.
//  - state=IDLE; tick prescaler and us counter cleared.
//  - Mid-transaction reset releases the bus on that same edge; no rx_start is issued.
//  Input and timing:
//  - dht_in passes through a 2-flop synchronizer; all decisions use the synced value.
//  - us_tick is one-cycle wide, every TICKS_PER_US clks.
//  - us_cnt is 20-bit, cleared on every state entry, incremented on us_tick, saturating.
//  FSM (all transitions registered):
//  - IDLE: start_req=1 -> START_LOW (busy=1 from next cycle); otherwise hold.
//  - START_LOW: dht_oe=1. us_cnt==START_LOW_US -> RELEASE.
//  - RELEASE: dht_oe=0.
//    - line low -> RESP_LOW;
//    - else us_cnt==RESP_TIMEOUT_US -> FAIL(01).
//  - RESP_LOW: on line rising edge,
//    - us_cnt in [RESP_MIN_US,RESP_MAX_US] -> RESP_HIGH;
//    - else FAIL(01).
//    - us_cnt>RESP_MAX_US while still low -> FAIL(01).
//  - RESP_HIGH: on line falling edge,
//    - us_cnt in window -> RECEIVE, with rx_start=1 for exactly one cycle on entry;
//    - else FAIL(01); overrun -> FAIL(01).
//  - RECEIVE: rx_done=1 -> CHECK (rx_data latched);
//    - us_cnt==FRAME_TIMEOUT_US -> FAIL(10).
//  - CHECK (1 cycle): chk==(b39:32+b31:24+b23:16+b15:8) mod 256.
//    - pass: hum<=rx_data[39:24], temp<=rx_data[23:8], valid=1 -> HOLDOFF.
//    - fail: FAIL(11).
//  - FAIL (1 cycle): err=1, err_code updated; hum/temp unchanged -> HOLDOFF.
//  - HOLDOFF: us_cnt==HOLDOFF_US -> IDLE (busy=0 on the IDLE cycle).
//  Request and pulse rules:
//  - start_req while busy is ignored, not queued.
//  - start_req on the same edge as HOLDOFF->IDLE is ignored.
//  - rx_done outside RECEIVE is ignored.
//  - rx_done and timeout on the same edge: rx_done wins.
//  - valid and err are never asserted together; each is exactly one cycle.
// STRUCTURE
//  - Shared package dht11_pkg: state encoding localparams (IDLE..HOLDOFF), err_code
//    constants ERR_NONE/ERR_RESP/ERR_TIMEOUT/ERR_CHKSUM, frame field bit positions.
//  - Sub-module dht11_us_tick: parameterized prescaler producing us_tick, clk/rst only.
//  - Synchronizer, edge detect, us_cnt, FSM and result registers live in this module.
// TESTING (bench uses reduced params: START_LOW_US=20, HOLDOFF_US=50, TICKS_PER_US=4)
//  1 Good read: sensor model answers 80us low/80us high, frame 0x3700_1900_50
//    -> rx_start once, valid=1, hum=0x3700, temp=0x1900.
//  2 Checksum bad: frame 0x3700_1900_51 -> err=1, err_code=11, hum/temp keep prior values.
//  3 No response: bus stays high after release -> err_code=01 at RESP_TIMEOUT_US+1 us;
//    dht_oe=0 throughout.
//  4 Short response: low phase 20us -> err_code=01, no rx_start.
//  5 Frame timeout: good response, rx_done never -> err_code=10 at 6000us after rx_start.
//  6 Busy and reset:
//    - start_req during HOLDOFF -> ignored, busy stays 1 until holdoff ends;
//    - rst=0 during START_LOW -> dht_oe=0 and busy=0 on that edge.

Source files
------------

// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 read sequencer.
//   state_e            : sequencer FSM states (IDLE..HOLDOFF)
//   ERR_*              : err_code values reported on a failed transaction
//   *_LSB              : bit positions of the fields inside the 40-bit frame
//   frame_chk_ok()     : checksum test on a received frame
package dht11_pkg;

  localparam int US_CNT_W = 20;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START_LOW = 4'd1,
    RELEASE   = 4'd2,
    RESP_LOW  = 4'd3,
    RESP_HIGH = 4'd4,
    RECEIVE   = 4'd5,
    CHECK     = 4'd6,
    FAIL      = 4'd7,
    HOLDOFF   = 4'd8
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RESP    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CHKSUM  = 2'b11;

  // Frame layout {hum_int, hum_dec, tmp_int, tmp_dec, chk}, 8 bits each.
  localparam int HUM_INT_LSB = 32;
  localparam int HUM_DEC_LSB = 24;
  localparam int TMP_INT_LSB = 16;
  localparam int TMP_DEC_LSB = 8;
  localparam int CHK_LSB     = 0;

  // Checksum is the low byte of the sum of the four data bytes.
  function automatic logic frame_chk_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[HUM_INT_LSB +: 8] + frame[HUM_DEC_LSB +: 8] +
          frame[TMP_INT_LSB +: 8] + frame[TMP_DEC_LSB +: 8];
    return sum == frame[CHK_LSB +: 8];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Free-running microsecond prescaler.
//   clk     in  system clock
//   rst     in  synchronous reset, active-low (clears the prescaler)
//   us_tick out one-cycle pulse every TICKS_PER_US clocks
module dht11_us_tick #(
  parameter int TICKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  output logic us_tick
);

  localparam int CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign us_tick = (cnt_q == LAST);

endmodule

// File: rtl/dht11_read_sequencer.sv
// Sequences one DHT11 read: host start pulse, sensor response qualification,
// receiver arming, checksum validation and the minimum re-read holdoff.
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   start_req  in   one-cycle request for a new reading (ignored while busy)
//   dht_in     in   raw bus level, asynchronous
//   dht_oe     out  1 = drive bus low, 0 = release
//   rx_start   out  one-cycle pulse arming the bit receiver
//   rx_done    in   one-cycle pulse: receiver frame complete
//   rx_data    in   40-bit frame, valid with rx_done
//   busy       out  high from accepted request until holdoff ends
//   hum, temp  out  {int,dec} results, updated only on a good frame
//   valid      out  one-cycle pulse: hum/temp just updated
//   err        out  one-cycle pulse: transaction failed
//   err_code   out  reason of the last failure, held until the next one
//   dbg_state  out  current FSM state
//
// Handshake: start_req, rx_start, rx_done, valid and err are single-cycle
// strobes with no back-pressure; a strobe is acted on only in the state that
// expects it and is otherwise dropped, never queued.
module dht11_read_sequencer
  import dht11_pkg::*;
#(
  parameter int TICKS_PER_US     = 50,
  parameter int START_LOW_US     = 18000,
  parameter int RESP_TIMEOUT_US  = 100,
  parameter int RESP_MIN_US      = 40,
  parameter int RESP_MAX_US      = 120,
  parameter int FRAME_TIMEOUT_US = 6000,
  parameter int HOLDOFF_US       = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_req,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic        rx_start,
  input  logic        rx_done,
  input  logic [39:0] rx_data,
  output logic        busy,
  output logic [15:0] hum,
  output logic [15:0] temp,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [3:0]  dbg_state
);

  localparam logic [US_CNT_W-1:0] START_LOW_CNT     = US_CNT_W'(START_LOW_US);
  localparam logic [US_CNT_W-1:0] RESP_TIMEOUT_CNT  = US_CNT_W'(RESP_TIMEOUT_US);
  localparam logic [US_CNT_W-1:0] RESP_MIN_CNT      = US_CNT_W'(RESP_MIN_US);
  localparam logic [US_CNT_W-1:0] RESP_MAX_CNT      = US_CNT_W'(RESP_MAX_US);
  localparam logic [US_CNT_W-1:0] FRAME_TIMEOUT_CNT = US_CNT_W'(FRAME_TIMEOUT_US);
  localparam logic [US_CNT_W-1:0] HOLDOFF_CNT       = US_CNT_W'(HOLDOFF_US);

  logic us_tick;

  dht11_us_tick #(.TICKS_PER_US(TICKS_PER_US)) u_us_tick (
    .clk     (clk),
    .rst     (rst),
    .us_tick (us_tick)
  );

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q, line_prev_q;
  logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d;
  logic [39:0]           frame_q, frame_d;
  logic [1:0]            fail_code_q, fail_code_d;
  logic                  dht_oe_q, dht_oe_d;
  logic                  rx_start_q, rx_start_d;
  logic                  busy_q, busy_d;
  logic [15:0]           hum_q, hum_d, temp_q, temp_d;
  logic                  valid_q, valid_d, err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  logic line_rise, line_fall, in_window;

  always_comb begin
    line_rise = sync2_q & ~line_prev_q;
    line_fall = ~sync2_q & line_prev_q;
    in_window = (us_cnt_q >= RESP_MIN_CNT) && (us_cnt_q <= RESP_MAX_CNT);

    state_d     = state_q;
    frame_d     = frame_q;
    fail_code_d = fail_code_q;

    case (state_q)
      IDLE: begin
        if (start_req) state_d = START_LOW;
      end
      START_LOW: begin
        if (us_cnt_q == START_LOW_CNT) state_d = RELEASE;
      end
      RELEASE: begin
        // Waiting for a falling edge rather than a low level skips the few
        // cycles where the synchronizer still shows our own start pulse.
        if (line_fall) begin
          state_d = RESP_LOW;
        end else if (us_cnt_q == RESP_TIMEOUT_CNT) begin
          state_d     = FAIL;
          fail_code_d = ERR_RESP;
        end
      end
      RESP_LOW: begin
        if (line_rise) begin
          if (in_window) begin
            state_d = RESP_HIGH;
          end else begin
            state_d     = FAIL;
            fail_code_d = ERR_RESP;
          end
        end else if (us_cnt_q > RESP_MAX_CNT) begin
          state_d     = FAIL;
          fail_code_d = ERR_RESP;
        end
      end
      RESP_HIGH: begin
        if (line_fall) begin
          if (in_window) begin
            state_d = RECEIVE;
          end else begin
            state_d     = FAIL;
            fail_code_d = ERR_RESP;
          end
        end else if (us_cnt_q > RESP_MAX_CNT) begin
          state_d     = FAIL;
          fail_code_d = ERR_RESP;
        end
      end
      RECEIVE: begin
        // rx_done takes priority over a timeout on the same cycle.
        if (rx_done) begin
          state_d = CHECK;
          frame_d = rx_data;
        end else if (us_cnt_q == FRAME_TIMEOUT_CNT) begin
          state_d     = FAIL;
          fail_code_d = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (frame_chk_ok(frame_q)) begin
          state_d = HOLDOFF;
        end else begin
          state_d     = FAIL;
          fail_code_d = ERR_CHKSUM;
        end
      end
      FAIL: begin
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (us_cnt_q == HOLDOFF_CNT) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // us_cnt restarts on every state change and saturates at all-ones.
    us_cnt_d = us_cnt_q;
    if (state_d != state_q)                 us_cnt_d = '0;
    else if (us_tick && (us_cnt_q != '1))   us_cnt_d = us_cnt_q + 1'b1;

    // Outputs are registered from the next state so they line up with it.
    dht_oe_d   = (state_d == START_LOW);
    rx_start_d = (state_d == RECEIVE) && (state_q != RECEIVE);
    busy_d     = (state_d != IDLE);
    valid_d    = (state_q == CHECK) && (state_d == HOLDOFF);
    err_d      = (state_q == FAIL);
    hum_d      = valid_d ? frame_q[HUM_DEC_LSB +: 16] : hum_q;
    temp_d     = valid_d ? frame_q[TMP_DEC_LSB +: 16] : temp_q;
    err_code_d = err_d ? fail_code_q : err_code_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      us_cnt_q    <= '0;
      frame_q     <= '0;
      fail_code_q <= ERR_NONE;
      dht_oe_q    <= 1'b0;
      rx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      hum_q       <= '0;
      temp_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      sync1_q     <= dht_in;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
      us_cnt_q    <= us_cnt_d;
      frame_q     <= frame_d;
      fail_code_q <= fail_code_d;
      dht_oe_q    <= dht_oe_d;
      rx_start_q  <= rx_start_d;
      busy_q      <= busy_d;
      hum_q       <= hum_d;
      temp_q      <= temp_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign dht_oe    = dht_oe_q;
  assign rx_start  = rx_start_q;
  assign busy      = busy_q;
  assign hum       = hum_q;
  assign temp      = temp_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule
